// File: rtl/code_check_sequencer.sv
// code_check_sequencer
// Compares the entered code against the stored password one digit per cycle.
// A shared read address drives both synchronous-read memories. The scan time
// depends only on the stored length, so it is the same whether or not the code
// is correct. The block also owns the consecutive-fail counter and the lockout
// timer that blocks further attempts.
module code_check_sequencer #(
  parameter int DIGIT_W        = 4,
  parameter int ADDR_W         = 3,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int ATT_W          = 2,
  parameter int LOCKOUT_CYCLES = 50000000,
  parameter int CNT_W          = 26
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               clear_attempts,
  input  logic [ADDR_W:0]    pass_len,
  input  logic [ADDR_W:0]    code_len,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DIGIT_W-1:0] pass_digit,
  input  logic [DIGIT_W-1:0] code_digit,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic               fail,
  output logic [ATT_W-1:0]   attempts,
  output logic               locked
);

  localparam int              MAX_LEN_I   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] MAX_LEN     = MAX_LEN_I[ADDR_W:0];
  localparam logic [ATT_W-1:0] ATT_SAT    = {ATT_W{1'b1}};
  localparam logic [ATT_W-1:0] ATT_LIMIT  = MAX_ATTEMPTS[ATT_W-1:0];
  localparam int              LOCK_LOAD_I = LOCKOUT_CYCLES - 1;
  localparam logic [CNT_W-1:0] LOCK_LOAD  = LOCK_LOAD_I[CNT_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_VERDICT = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W:0]    len_q, len_d;         // digits to scan, captured at start
  logic [ADDR_W:0]    rd_cnt_q, rd_cnt_d;   // reads issued so far
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               rd_valid_q, rd_valid_d; // memory data this cycle belongs to a read
  logic               mismatch_q, mismatch_d;
  logic               nopass_q, nopass_d;   // attempt made with no password stored
  logic [ATT_W-1:0]   attempts_q, attempts_d;
  logic [CNT_W-1:0]   timer_q, timer_d;

  logic [ADDR_W:0]    pass_len_c;
  logic [ADDR_W:0]    code_len_c;
  logic [ATT_W-1:0]   att_inc;
  logic               issue;

  // Clamp lengths, saturating attempt increment, read-issue condition
  always_comb begin
    pass_len_c = (pass_len > MAX_LEN) ? MAX_LEN : pass_len;
    code_len_c = (code_len > MAX_LEN) ? MAX_LEN : code_len;
    att_inc    = (attempts_q == ATT_SAT) ? attempts_q : attempts_q + 1'b1;
    issue      = (state_q == S_SCAN) && (rd_cnt_q < len_q);
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_addr_d  = '0;
    rd_valid_d = 1'b0;
    mismatch_d = mismatch_q;
    nopass_d   = nopass_q;
    attempts_d = attempts_q;
    timer_d    = timer_q;
    busy       = 1'b0;
    done       = 1'b0;
    match      = 1'b0;
    fail       = 1'b0;
    locked     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A clear arriving with start is applied before the new attempt.
        if (clear_attempts) begin
          attempts_d = '0;
        end
        if (start) begin
          len_d    = pass_len_c;
          rd_cnt_d = '0;
          if (pass_len_c == '0) begin
            // No password stored: refuse immediately without counting it.
            nopass_d   = 1'b1;
            mismatch_d = 1'b1;
            state_d    = S_VERDICT;
          end else begin
            // A length mismatch is only recorded; the full stored length
            // is still scanned so timing does not leak the result.
            nopass_d   = 1'b0;
            mismatch_d = (code_len_c != pass_len_c);
            state_d    = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        busy = 1'b1;
        if (issue) begin
          rd_cnt_d   = rd_cnt_q + 1'b1;
          rd_valid_d = 1'b1;
          if ((rd_cnt_q + 1'b1) < len_q) begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        if (rd_valid_q && (pass_digit != code_digit)) begin
          mismatch_d = 1'b1;
        end
        // Data for the final read is being compared now.
        if (rd_valid_q && !issue) begin
          state_d = S_VERDICT;
        end
      end

      S_VERDICT: begin
        busy    = 1'b1;
        done    = 1'b1;
        match   = ~mismatch_q;
        fail    = mismatch_q;
        state_d = S_IDLE;
        if (!nopass_q) begin
          if (!mismatch_q) begin
            attempts_d = '0;
          end else begin
            attempts_d = att_inc;
            if (att_inc == ATT_LIMIT) begin
              state_d = S_LOCKOUT;
              timer_d = LOCK_LOAD;
            end
          end
        end
      end

      S_LOCKOUT: begin
        locked = 1'b1;
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          attempts_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      rd_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_valid_q <= 1'b0;
      mismatch_q <= 1'b0;
      nopass_q   <= 1'b0;
      attempts_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_valid_q <= rd_valid_d;
      mismatch_q <= mismatch_d;
      nopass_q   <= nopass_d;
      attempts_q <= attempts_d;
      timer_q    <= timer_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign attempts = attempts_q;

endmodule

// File: tb/tb_code_check_sequencer.sv
// Bench for code_check_sequencer: timeline model of each attempt plus
// directed scenarios with hand-computed cycle numbers.
module tb_code_check_sequencer;
  localparam int ADDR_W  = 3;
  localparam int DIGIT_W = 4;
  localparam int MAXL    = 8;
  localparam int LOCK_N  = 10;
  localparam int MAX_ATT = 3;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic               clear_attempts = 1'b0;
  logic [ADDR_W:0]    pass_len = '0;
  logic [ADDR_W:0]    code_len = '0;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DIGIT_W-1:0] pass_digit;
  logic [DIGIT_W-1:0] code_digit;
  logic               busy, done, match, fail, locked;
  logic [1:0]         attempts;

  logic [DIGIT_W-1:0] pass_mem [MAXL];
  logic [DIGIT_W-1:0] code_mem [MAXL];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model state: 0 idle, 1 attempt in progress, 2 locked out
  int m_st = 0, m_k = 0, m_L = 0, m_done_at = 0, m_left = 0, m_att = 0;
  bit m_vfail = 1'b0, m_nopass = 1'b0;

  always #5 clk = ~clk;

  code_check_sequencer #(
    .DIGIT_W(DIGIT_W), .ADDR_W(ADDR_W), .MAX_ATTEMPTS(MAX_ATT), .ATT_W(2),
    .LOCKOUT_CYCLES(LOCK_N), .CNT_W(26)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .clear_attempts(clear_attempts),
    .pass_len(pass_len), .code_len(code_len), .rd_addr(rd_addr),
    .pass_digit(pass_digit), .code_digit(code_digit), .busy(busy), .done(done),
    .match(match), .fail(fail), .attempts(attempts), .locked(locked)
  );

  // synchronous-read memories, one cycle latency
  always @(posedge clk) begin
    pass_digit <= pass_mem[rd_addr];
    code_digit <= code_mem[rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clampl(input int v);
    return (v > MAXL) ? MAXL : v;
  endfunction

  // model: verdict decided from the memory contents at start, then a timeline
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetn) begin
        m_st  = 0;
        m_att = 0;
      end else begin
        case (m_st)
          0: begin
            if (clear_attempts) m_att = 0;
            if (start) begin
              m_L      = clampl(int'(pass_len));
              m_nopass = (m_L == 0);
              m_vfail  = m_nopass || (clampl(int'(code_len)) != m_L);
              for (int i = 0; i < m_L; i++)
                if (pass_mem[i] != code_mem[i]) m_vfail = 1'b1;
              m_done_at = m_nopass ? 1 : m_L + 2;
              m_k  = 0;
              m_st = 1;
            end
          end
          1: begin
            if (m_k == m_done_at) begin
              m_st = 0;
              if (!m_nopass) begin
                if (!m_vfail) m_att = 0;
                else begin
                  if (m_att < 3) m_att++;
                  if (m_att == MAX_ATT) begin
                    m_st   = 2;
                    m_left = LOCK_N;
                  end
                end
              end
            end
          end
          default: begin
            m_left--;
            if (m_left == 0) begin
              m_st  = 0;
              m_att = 0;
            end
          end
        endcase
      end
      if (m_st == 1) m_k++;
    end
  end

  // per-cycle comparison against the model
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_match", match, 0);
        check("rst_fail", fail, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_attempts", attempts, 0);
        check("rst_locked", locked, 0);
      end else begin
        check("busy", busy, (m_st == 1));
        check("done", done, (m_st == 1 && m_k == m_done_at));
        check("match", match, (m_st == 1 && m_k == m_done_at && !m_vfail));
        check("fail", fail, (m_st == 1 && m_k == m_done_at && m_vfail));
        check("rd_addr", rd_addr, (m_st == 1 && m_k >= 1 && m_k <= m_L) ? m_k - 1 : 0);
        check("attempts", attempts, m_att);
        check("locked", locked, (m_st == 2));
      end
    end
  end

  // one attempt; returns at the negedge of the cycle after the verdict
  task automatic do_op(input int plen, input int clen, input int exp_l,
                       input int exp_done, input bit exp_match, input bit hold_start);
    int got;
    got = -1;
    @(posedge clk); #2;
    pass_len = plen[ADDR_W:0];
    code_len = clen[ADDR_W:0];
    start    = 1'b1;
    @(posedge clk); #2;
    if (!hold_start) start = 1'b0;
    pass_len = 4'd5;   // changes after the start sample must not matter
    code_len = 4'd1;
    for (int c = 1; c <= 14 && got < 0; c++) begin
      @(negedge clk);
      if (c <= exp_l) check("lit_rd_addr", rd_addr, c - 1);
      if (done) begin
        got = c;
        check("lit_match", match, exp_match);
        check("lit_fail", fail, !exp_match);
      end
    end
    check("lit_done_cycle", got, exp_done);
    @(negedge clk);
    if (hold_start) start = 1'b0;
    $display("op plen=%0d clen=%0d done_cycle=%0d match=%0d attempts=%0d locked=%0d",
             plen, clen, got, exp_match, attempts, locked);
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    int n_lock;
    int nd;
    for (int i = 0; i < MAXL; i++) begin
      pass_mem[i] = '0;
      code_mem[i] = '0;
    end
    pass_mem[0] = 4'd3; pass_mem[1] = 4'd1; pass_mem[2] = 4'd4;
    code_mem[0] = 4'd3; code_mem[1] = 4'd1; code_mem[2] = 4'd4;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lit_reset_busy", busy, 0);
    check("lit_reset_attempts", attempts, 0);
    check("lit_reset_locked", locked, 0);
    @(posedge clk); #2;
    resetn = 1'b1;

    // correct code
    do_op(3, 3, 3, 5, 1'b1, 1'b0);
    check("lit_att_after_match", attempts, 0);

    // three wrong codes -> lockout
    code_mem[2] = 4'd5;
    do_op(3, 3, 3, 5, 1'b0, 1'b0);
    check("lit_att_1", attempts, 1);
    do_op(3, 3, 3, 5, 1'b0, 1'b0);
    check("lit_att_2", attempts, 2);
    do_op(3, 3, 3, 5, 1'b0, 1'b0);
    check("lit_att_3", attempts, 3);
    check("lit_locked_on", locked, 1);

    // lockout length, with start and clear ignored meanwhile
    n_lock = 0;
    while (locked && n_lock < 30) begin
      n_lock++;
      if (n_lock == 3) start = 1'b1;
      if (n_lock == 4) begin start = 1'b0; clear_attempts = 1'b1; end
      if (n_lock == 5) clear_attempts = 1'b0;
      if (n_lock == 6) check("lit_att_in_lock", attempts, 3);
      @(negedge clk);
    end
    check("lit_lock_cycles", n_lock, LOCK_N);
    check("lit_att_after_lock", attempts, 0);
    check("lit_busy_after_lock", busy, 0);
    $display("lockout cycles=%0d attempts=%0d", n_lock, attempts);

    // length mismatch with equal leading digits: full scan, fail
    code_mem[2] = 4'd4;
    do_op(3, 2, 3, 5, 1'b0, 1'b0);
    check("lit_att_lenmis", attempts, 1);

    // no password stored
    do_op(0, 3, 0, 1, 1'b0, 1'b0);
    check("lit_att_nopass", attempts, 1);

    // clear in idle
    @(posedge clk); #2; clear_attempts = 1'b1;
    @(posedge clk); #2; clear_attempts = 1'b0;
    @(negedge clk);
    check("lit_att_cleared", attempts, 0);
    $display("clear attempts=%0d", attempts);

    // one fail, then reset in scan cycle 2
    code_mem[2] = 4'd5;
    do_op(3, 3, 3, 5, 1'b0, 1'b0);
    code_mem[2] = 4'd4;
    @(posedge clk); #2; pass_len = 4'd3; code_len = 4'd3; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    @(posedge clk); #2; resetn = 1'b0;
    @(negedge clk);
    check("lit_midrst_busy", busy, 0);
    check("lit_midrst_addr", rd_addr, 0);
    check("lit_midrst_att", attempts, 0);
    @(posedge clk); #2; resetn = 1'b1;
    count_dones(10, nd);
    check("lit_midrst_no_done", nd, 0);
    $display("mid-scan reset dones=%0d attempts=%0d", nd, attempts);

    // start held through scan and verdict
    do_op(3, 3, 3, 5, 1'b1, 1'b1);
    count_dones(12, nd);
    check("lit_no_second_verdict", nd, 0);

    // lengths above MAX_LEN clamp to 8 digits
    do_op(15, 12, 8, 10, 1'b1, 1'b0);
    code_mem[7] = 4'd9;
    do_op(15, 8, 8, 10, 1'b0, 1'b0);
    check("lit_att_clamp", attempts, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
